// File: rtl/dmem_arb_pkg.sv
// Shared types and width helpers for the CPU/DMA data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {ARB_CPU = 1'b0, ARB_DMA = 1'b1} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_CPU = 2'd1, GNT_DMA = 2'd2} gnt_sel_t;

  localparam int BURST_LEN_DEF = 4;
  localparam int MAX_WAIT_DEF  = 8;

  // Counter must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int BEAT_W = cnt_w(BURST_LEN_DEF);
  localparam int WAIT_W = cnt_w(MAX_WAIT_DEF);

endpackage

// File: rtl/dmem_arb_if.sv
// CPU, DMA and memory-side signals of the arbiter; master is the requester/memory side.
interface dmem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd, cpu_rd;
  logic          dma_req, dma_we, dma_gnt;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wd, dma_rd;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    output dma_req, dma_we, dma_addr, dma_wd,
    output mem_rd,
    input  cpu_rd, cpu_stall, dma_rd, dma_gnt, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  dma_req, dma_we, dma_addr, dma_wd,
    input  mem_rd,
    output cpu_rd, cpu_stall, dma_rd, dma_gnt, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arb_mux.sv
// Port-to-memory mux; with no grant the CPU port is presented but never written.
module dmem_arb_mux
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  gnt_sel_t      sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wd,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd
);

  always_comb begin
    mem_we = 1'b0;
    mem_a  = cpu_addr;
    mem_wd = cpu_wd;
    unique case (sel)
      GNT_CPU: mem_we = cpu_we;
      GNT_DMA: begin
        mem_we = dma_we;
        mem_a  = dma_addr;
        mem_wd = dma_wd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority data-memory arbiter with DMA starvation forcing and short DMA bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input logic       clk,
  input logic       rst_n,
  dmem_arb_if.slave bus
);

  localparam int BW = cnt_w(BURST_LEN);
  localparam int WW = cnt_w(MAX_WAIT);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wait_q, wait_d;
  gnt_sel_t      sel_raw, sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_CPU;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    sel_raw = GNT_NONE;
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      ARB_CPU: begin
        if (bus.dma_req && wait_q == WW'(MAX_WAIT)) begin
          sel_raw = GNT_DMA;
        end else if (bus.cpu_req) begin
          sel_raw = GNT_CPU;
        end else if (bus.dma_req) begin
          sel_raw = GNT_DMA;
          if (BURST_LEN > 1) begin
            state_d = ARB_DMA;
            beat_d  = BW'(1);
          end
        end
      end
      ARB_DMA: begin
        if (bus.dma_req) begin
          sel_raw = GNT_DMA;
          beat_d  = beat_q + BW'(1);
          if (beat_d == BW'(BURST_LEN)) begin
            state_d = ARB_CPU;
            beat_d  = '0;
          end
        end else begin
          // Requester went quiet: abandon the burst and hand back to the CPU.
          state_d = ARB_CPU;
          beat_d  = '0;
        end
      end
      default: state_d = ARB_CPU;
    endcase

    wait_d = wait_q;
    if (!bus.dma_req || sel_raw == GNT_DMA) wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))       wait_d = wait_q + WW'(1);
  end

  // Grants are suppressed combinationally while reset is held, even mid-burst.
  always_comb begin
    sel           = rst_n ? sel_raw : GNT_NONE;
    bus.dma_gnt   = (sel == GNT_DMA);
    bus.cpu_stall = bus.cpu_req & (sel != GNT_CPU);
    bus.cpu_rd    = bus.mem_rd;
    bus.dma_rd    = bus.mem_rd;
  end

  dmem_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .sel      (sel),
    .cpu_we   (bus.cpu_we),
    .cpu_addr (bus.cpu_addr),
    .cpu_wd   (bus.cpu_wd),
    .dma_we   (bus.dma_we),
    .dma_addr (bus.dma_addr),
    .dma_wd   (bus.dma_wd),
    .mem_we   (bus.mem_we),
    .mem_a    (bus.mem_a),
    .mem_wd   (bus.mem_wd)
  );

`ifndef SYNTHESIS
  a_dma_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    bus.dma_req |-> bus.dma_addr[1:0] == 2'b00);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus hand-written contention/burst/reset sequences.
module tb_dmem_arbiter;

  logic clk, rst_n;
  int   errors = 0;
  int   checks = 0;

  dmem_arb_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .BURST_LEN(4), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory, combinational read, write on posedge.
  logic [31:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        xs, xg, xwe;
    logic [31:0] xa;
    logic        ck_rd;
    logic [31:0] xrd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic xs, logic xg, logic xwe, logic [31:0] xa,
                              logic ck_rd, logic [31:0] xrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.xs = xs; v.xg = xg; v.xwe = xwe; v.xa = xa;
    v.ck_rd = ck_rd; v.xrd = xrd;
    return v;
  endfunction

  task automatic drive(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                       logic dr, logic dw, logic [31:0] da, logic [31:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wd = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wd = dd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle();
  endtask

  // Both ports request every cycle; only every 9th cycle goes to the DMA.
  task automatic contend(input string nm, input int n);
    for (int k = 1; k <= n; k++) begin
      drive(1, 0, 32'h10, 32'h0, 1, 1, 32'h60, 32'h5000_0000 + k);
      #4;
      chk($sformatf("%s dma_gnt c%0d", nm, k), 32'(bus.dma_gnt), 32'((k % 9) == 0));
      chk($sformatf("%s stall c%0d", nm, k), 32'(bus.cpu_stall), 32'((k % 9) == 0));
      if ((k % 9) == 0) chk($sformatf("%s mem_a c%0d", nm, k), bus.mem_a, 32'h60);
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Test 1: CPU write then read back.
    vt.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,1,32'h10, 0,0));
    vt.push_back(mk(1,0,32'h10,0,            0,0,0,0, 0,0,0,32'h10, 1,32'hDEADBEEF));
    // Test 2: six DMA writes with CPU idle (burst of 4 then a fresh burst).
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(0,0,0,0, 1,1,32'h40+4*i,32'hA000_0000+i, 0,1,1,32'h40+4*i, 0,0));
    // Still in ARB_DMA after beat 6: CPU stalls one cycle while the burst is abandoned.
    vt.push_back(mk(1,0,32'h40,0, 0,0,0,0, 1,0,0,32'h40, 1,32'hA000_0000));
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(1,0,32'h40+4*i,0, 0,0,0,0, 0,0,0,32'h40+4*i, 1,32'hA000_0000+i));

    // Reset state with both ports requesting.
    rst_n = 1'b0;
    drive(1, 1, 32'h24, 32'h1111, 1, 1, 32'h30, 32'h2222);
    #3;
    chk("rst dma_gnt", 32'(bus.dma_gnt), 0);
    chk("rst mem_we", 32'(bus.mem_we), 0);
    chk("rst stall", 32'(bus.cpu_stall), 1);
    chk("rst mem_a", bus.mem_a, 32'h24);
    chk("rst mem_wd", bus.mem_wd, 32'h1111);
    next_cycle();
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      #4;
      chk($sformatf("v%0d stall", i), 32'(bus.cpu_stall), 32'(vt[i].xs));
      chk($sformatf("v%0d dma_gnt", i), 32'(bus.dma_gnt), 32'(vt[i].xg));
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vt[i].xwe));
      chk($sformatf("v%0d mem_a", i), bus.mem_a, vt[i].xa);
      if (vt[i].ck_rd) chk($sformatf("v%0d cpu_rd", i), bus.cpu_rd, vt[i].xrd);
      next_cycle();
    end

    // Test 3: starvation forcing repeats every 9 cycles.
    contend("starve", 27);
    idle();

    // Test 4: CPU arrives one cycle into a DMA burst.
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h70, 32'h7);
    #4; chk("mid c0 dma_gnt", 32'(bus.dma_gnt), 1);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 0, 32'h14, 32'h0, 1, 1, 32'h70 + 4*c, 32'h7 + c);
      #4;
      chk($sformatf("mid c%0d dma_gnt", c), 32'(bus.dma_gnt), 1);
      chk($sformatf("mid c%0d stall", c), 32'(bus.cpu_stall), 1);
      next_cycle();
    end
    drive(1, 0, 32'h14, 32'h0, 1, 1, 32'h80, 32'hB);
    #4;
    chk("mid c4 dma_gnt", 32'(bus.dma_gnt), 0);
    chk("mid c4 stall", 32'(bus.cpu_stall), 0);
    next_cycle();
    idle();

    // Test 5: burst abandoned after two beats.
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h90 + 4*c, 32'hC + c);
      #4; chk($sformatf("abn beat%0d dma_gnt", c), 32'(bus.dma_gnt), 1);
      next_cycle();
    end
    drive(1, 1, 32'h18, 32'h55, 0, 0, 32'h0, 32'h0);
    #4;
    chk("abn drop stall", 32'(bus.cpu_stall), 1);
    chk("abn drop mem_we", 32'(bus.mem_we), 0);
    next_cycle();
    drive(1, 1, 32'h18, 32'h55, 0, 0, 32'h0, 32'h0);
    #4;
    chk("abn cpu stall", 32'(bus.cpu_stall), 0);
    chk("abn cpu mem_we", 32'(bus.mem_we), 1);
    next_cycle();
    idle();

    // Test 6: asynchronous reset in the middle of a burst.
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 32'h0, 32'h0, 1, 1, 32'hA0 + 4*c, 32'hE + c);
      #4; chk($sformatf("arst beat%0d dma_gnt", c), 32'(bus.dma_gnt), 1);
      next_cycle();
    end
    drive(1, 1, 32'h20, 32'h77, 1, 1, 32'hA8, 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst dma_gnt", 32'(bus.dma_gnt), 0);
    chk("arst mem_we", 32'(bus.mem_we), 0);
    chk("arst stall", 32'(bus.cpu_stall), 1);
    chk("arst mem_a", bus.mem_a, 32'h20);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First cycle after release: CPU wins, then DMA is forced on the 9th.
    contend("post", 9);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (word-addressed, combinational read, write on posedge) between two requesters: the pipeline CPU MEM stage (port 0) and a DMA/loader engine (port 1) that streams RSA operands and results.
- Sits between the CPU/DMA and the memory.
- Default priority goes to the CPU. A starvation counter forces single DMA beats. Short DMA bursts run when the CPU is idle.
- Stalls the CPU pipeline whenever the CPU loses arbitration.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports.
- BURST_LEN, 4, maximum DMA beats per burst once a burst is entered (≥1).
- MAX_WAIT, 8, number of consecutive cycles a pending DMA request may be denied before it is forced through (≥1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU byte address.
- cpu_wd  in  DW  CPU write data.
- cpu_rd  out  DW  read data to CPU.
- cpu_stall  out  1  CPU denied this cycle; pipeline must hold.
- dma_req  in  1  DMA beat request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  AW  DMA byte address (word-aligned).
- dma_wd  in  DW  DMA write data.
- dma_rd  out  DW  read data to DMA.
- dma_gnt  out  1  DMA beat accepted this cycle.
- mem_we  out  1  to memory write enable.
- mem_a  out  AW  to memory address.
- mem_wd  out  DW  to memory write data.
- mem_rd  in  DW  from memory read data.

Behaviour:
- Grant decision is combinational from current state, counters and requests. Zero-cycle latency: the granted beat reaches memory in the same cycle, and a write commits at the next posedge.
- Exactly one of cpu_gnt (internal) or dma_gnt per cycle; both may be 0.
- cpu_stall = cpu_req & ~cpu_gnt.
- Muxing:
  - mem_a and mem_wd come from the granted port. With no grant they default to the CPU port.
  - mem_we = granted port's we & grant. With no grant, mem_we = 0.
- cpu_rd and dma_rd both = mem_rd, unconditionally.
- States (package enum arb_state_t):
  - ARB_CPU:
    - dma_req & (wait_cnt == MAX_WAIT): grant DMA (forced beat, even if cpu_req). Stay ARB_CPU.
    - else cpu_req: grant CPU.
    - else dma_req: grant DMA. If BURST_LEN > 1, go to ARB_DMA with beat_cnt = 1.
    - else idle.
  - ARB_DMA:
    - dma_req: grant DMA; beat_cnt++. When the granted beat makes beat_cnt == BURST_LEN, return to ARB_CPU.
    - !dma_req: no grant. Return to ARB_CPU immediately (burst abandoned).
    - cpu_req during ARB_DMA is stalled. Worst-case CPU stall is BURST_LEN-1 cycles.
- wait_cnt:
  - Increments when dma_req & ~dma_gnt; saturates at MAX_WAIT.
  - Clears to 0 on dma_gnt or when dma_req is low.
- Simultaneous cpu_req & dma_req in ARB_CPU with wait_cnt < MAX_WAIT: CPU wins; wait_cnt increments.
- Reset (rst_n low, asynchronous, including mid-burst):
  - State = ARB_CPU; wait_cnt = 0; beat_cnt = 0.
  - All grants forced 0: dma_gnt = 0, mem_we = 0, cpu_stall = cpu_req. mem_a/mem_wd pass the CPU port.
  - First cycle after release behaves as ARB_CPU with wait_cnt = 0.
- dma_addr[1:0] != 0 is illegal. Covered by a simulation assertion; no hardware check.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t {ARB_CPU, ARB_DMA}.
  - Grant-select enum {GNT_NONE, GNT_CPU, GNT_DMA}.
  - Localparam widths for beat_cnt ($clog2(BURST_LEN+1)) and wait_cnt ($clog2(MAX_WAIT+1)).
- One natural sub-module: dmem_arb_mux. Purely combinational port-to-memory mux driven by the grant-select enum.
- FSM and counters live in dmem_arbiter.

Test Plan:
1. Reset then CPU only:
   - Stimulus: cpu_req=1, we=1, addr=0x10, wd=0xDEADBEEF, then read 0x10.
   - Required: cpu_stall=0 both cycles; mem_we=1 on the first cycle; cpu_rd=0xDEADBEEF.
2. CPU idle, DMA burst:
   - Stimulus: dma_req held for 6 cycles, writes to 0x40..0x54.
   - Required: beats 1-4 granted in ARB_DMA; return to ARB_CPU; beats 5-6 granted (new burst entry). Memory holds all 6 words.
3. Contention/starvation with MAX_WAIT=8:
   - Stimulus: cpu_req and dma_req both held high continuously.
   - Required: dma_gnt=1 on the 9th cycle only, with cpu_stall=1 that cycle. Pattern repeats every 9 cycles.
4. CPU arrives mid-burst:
   - Stimulus: DMA burst starts at cycle 0; cpu_req rises at cycle 1.
   - Required: cpu_stall=1 in cycles 1-3; CPU granted at cycle 4.
5. Burst abandon:
   - Stimulus: dma_req drops after 2 beats.
   - Required: next cycle is ARB_CPU; a pending cpu_req is granted with no stall.
6. Async reset mid-burst:
   - Stimulus: rst_n low between clock edges after beat 2.
   - Required: dma_gnt=0 and mem_we=0 immediately. After release, a CPU request is granted first cycle; wait_cnt=0.
